ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_if.sv | 24 ++
 rtl/ps2_host_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Host-side bundle for the PS/2 host transmitter: byte request handshake, status pulses,
// and the raw/open-drain PS/2 line signals. The DUT uses the slave modport.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       err;
    logic       busy;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, done, err, busy
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, ps2_clk_oe, ps2_data_oe, done, err, busy
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop,
// device ACK check and watchdog. Define PS2_TX_RESEND_EN to retry once on the first NACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input logic          CLK100MHz,
    input logic          reset_n,
    ps2_host_tx_if.slave bus
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic               parity_q, parity_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic [2:0]         clk_sync_q, clk_sync_d;
    logic [1:0]         data_sync_q, data_sync_d;
    logic               clk_oe_q, clk_oe_d;
    logic               data_oe_q, data_oe_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
`ifdef PS2_TX_RESEND_EN
    logic               resend_q, resend_d;
`endif

    logic clk_fall;
    logic wd_expired;

    // Stage [1] is the synchronized line; stage [2] is its previous value for edge detection.
    assign clk_fall   = clk_sync_q[2] & ~clk_sync_q[1];
    assign wd_expired = (wd_cnt_q >= WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        data_d      = data_q;
        parity_d    = parity_q;
        bit_cnt_d   = bit_cnt_q;
        inh_cnt_d   = inh_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        clk_sync_d  = {clk_sync_q[1:0], bus.ps2_clk_in};
        data_sync_d = {data_sync_q[0], bus.ps2_data_in};
`ifdef PS2_TX_RESEND_EN
        resend_d    = resend_q;
`endif

        if (state_q inside {SHIFT, ACK, WAIT_IDLE}) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (bus.tx_valid && ready_q) begin
                    data_d    = bus.tx_data;
                    parity_d  = ~^bus.tx_data;
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
`ifdef PS2_TX_RESEND_EN
                    resend_d  = 1'b0;
`endif
                end
            end

            INHIBIT: begin
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end

            REQ: begin
                clk_oe_d  = 1'b0;
                bit_cnt_d = '0;
                wd_cnt_d  = '0;
                state_d   = SHIFT;
            end

            SHIFT: begin
                if (wd_expired) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end
                end
            end

            ACK: begin
                // The ACK sample wins over a watchdog expiry on the same cycle.
                if (clk_fall) begin
                    if (!data_sync_q[1]) begin
                        state_d = WAIT_IDLE;
                    end else begin
`ifdef PS2_TX_RESEND_EN
                        if (!resend_q) begin
                            resend_d  = 1'b1;
                            inh_cnt_d = '0;
                            clk_oe_d  = 1'b1;
                            state_d   = INHIBIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
`else
                        err_d   = 1'b1;
                        state_d = IDLE;
`endif
                    end
                end else if (wd_expired) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end
            end

            WAIT_IDLE: begin
                if (wd_expired) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else if (clk_sync_q[1] && data_sync_q[1]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge CLK100MHz) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            parity_q    <= 1'b0;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            // NOTE: synchronizers reset to the idle (released, high) line level so no false edge follows reset.
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
`ifdef PS2_TX_RESEND_EN
            resend_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            parity_q    <= parity_d;
            bit_cnt_q   <= bit_cnt_d;
            inh_cnt_q   <= inh_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
`ifdef PS2_TX_RESEND_EN
            resend_q    <= resend_d;
`endif
        end
    end

    assign bus.tx_ready    = ready_q;
    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out of the host
// and the captured bits, pulses and line states are compared with hand-computed values.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 3000;
    localparam int HALF = 40;

    logic CLK100MHz = 1'b0;
    logic reset_n   = 1'b0;
    logic dev_clk   = 1'b1;
    logic dev_data  = 1'b1;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int err_before11 = 0;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK100MHz(CLK100MHz),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 CLK100MHz = ~CLK100MHz;

    // Open-drain bus: either side can pull a line low.
    assign bus.ps2_clk_in  = dev_clk  & ~bus.ps2_clk_oe;
    assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

    always @(negedge CLK100MHz) begin
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.err)  err_cnt  <= err_cnt + 1;
        if (bus.done && bus.err) both_cnt <= both_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK100MHz);
            #1;
        end
    endtask

    // Measures the clock-only inhibit phase and the one-cycle request phase, ending on the
    // first sample after the clock line is released.
    task automatic await_rts();
        int n;
        n = 0;
        while (bus.ps2_clk_oe && !bus.ps2_data_oe && n < 1000) begin
            n++;
            tick(1);
        end
        check("inhibit_cycles", n, INH);
        n = 0;
        while (bus.ps2_clk_oe && bus.ps2_data_oe && n < 100) begin
            n++;
            tick(1);
        end
        check("req_cycles", n, 1);
        check("start_bit_clk_released", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b01);
    endtask

    task automatic send(input logic [7:0] b, input bit hold, input logic [7:0] hold_data);
        int n;
        n = 0;
        while (!bus.tx_ready && n < 10000) begin
            n++;
            tick(1);
        end
        check("ready_before_send", bus.tx_ready, 1'b1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        tick(1);
        if (hold) bus.tx_data = hold_data;
        else      bus.tx_valid = 1'b0;
        check("busy_after_accept", bus.busy, 1'b1);
        await_rts();
    endtask

    // Behavioural device: 11 clock pulses, samples data on rising edges 1..10,
    // pulls data low after rising edge 10 when acking.
    task automatic device(input bit ack, input int abort_edge, input int inject_edge,
                          output logic [9:0] bits);
        bits = '0;
        tick(HALF);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) err_before11 = err_cnt;
            dev_clk = 1'b0;
            if (i == abort_edge) begin
                reset_n = 1'b0;
                tick(1);
                check("reset_clk_oe", bus.ps2_clk_oe, 1'b0);
                check("reset_data_oe", bus.ps2_data_oe, 1'b0);
                check("reset_busy", bus.busy, 1'b0);
                check("reset_ready", bus.tx_ready, 1'b1);
                dev_clk = 1'b1;
                reset_n = 1'b1;
                return;
            end
            if (i == inject_edge) begin
                tick(5);
                bus.tx_data  = 8'hAA;
                bus.tx_valid = 1'b1;
                tick(1);
                bus.tx_valid = 1'b0;
                check("ready_low_in_shift", bus.tx_ready, 1'b0);
                tick(HALF - 6);
            end else begin
                tick(HALF);
            end
            dev_clk = 1'b1;
            if (i <= 10) bits[i-1] = bus.ps2_data_in;
            if (i == 10 && ack) dev_data = 1'b0;
            tick(HALF);
        end
        dev_data = 1'b1;
    endtask

    initial begin
        logic [9:0] bits;
        logic [9:0] bits2;
        int d0, e0, n;

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        tick(4);
        check("rst_ready", bus.tx_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
        check("rst_done_err", {bus.done, bus.err}, 2'b00);
        reset_n = 1'b1;
        tick(3);
        check("idle_after_rst", {bus.tx_ready, bus.busy}, 2'b10);

        // 0xED acked: LSB-first 1,0,1,1,0,1,1,1; six ones -> odd parity 1; stop 1.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hED, 1'b0, 8'h00);
        device(1'b1, 0, 0, bits);
        tick(10);
        check("ed_byte", bits[7:0], 8'hED);
        check("ed_parity", bits[8], 1'b1);
        check("ed_stop", bits[9], 1'b1);
        check("ed_done_once", done_cnt - d0, 1);
        check("ed_no_err", err_cnt - e0, 0);
        check("ed_ready_back", bus.tx_ready, 1'b1);

        // Back-to-back 0x00 then 0x01 with tx_valid held high throughout.
        d0 = done_cnt;
        send(8'h00, 1'b1, 8'h01);
        check("b2b_ready_low_busy", bus.tx_ready, 1'b0);
        device(1'b1, 0, 0, bits);
        n = 0;
        while (!bus.done && n < 100) begin
            n++;
            tick(1);
        end
        check("b2b_first_done", bus.done, 1'b1);
        check("b2b_not_accepted_before_done", done_cnt - d0, 0);
        tick(1);
        bus.tx_valid = 1'b0;
        check("b2b_second_accepted", bus.busy, 1'b1);
        await_rts();
        device(1'b1, 0, 0, bits2);
        tick(10);
        check("b2b_byte0", bits[7:0], 8'h00);
        check("b2b_parity0", bits[8], 1'b1);
        check("b2b_byte1", bits2[7:0], 8'h01);
        check("b2b_parity1", bits2[8], 1'b0);
        check("b2b_done_twice", done_cnt - d0, 2);

        // Device never clocks: err 3000 cycles after clock release.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hED, 1'b0, 8'h00);
        n = 0;
        while (!bus.err && n < 5000) begin
            n++;
            tick(1);
        end
        check("timeout_latency", n, TMO);
        check("timeout_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
        tick(5);
        check("timeout_err_once", err_cnt - e0, 1);
        check("timeout_no_done", done_cnt - d0, 0);
        check("timeout_idle", bus.tx_ready, 1'b1);

        // NACK: 0x5A, four ones -> parity 1.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h5A, 1'b0, 8'h00);
        device(1'b0, 0, 0, bits);
        check("nack_byte", bits[7:0], 8'h5A);
        check("nack_parity", bits[8], 1'b1);
        check("nack_no_err_before_edge11", err_before11 - e0, 0);
`ifdef PS2_TX_RESEND_EN
        check("resend_no_err", err_cnt - e0, 0);
        check("resend_busy", bus.busy, 1'b1);
        check("resend_start_bit", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b01);
        device(1'b0, 0, 0, bits2);
        check("resend_same_byte", bits2[7:0], 8'h5A);
`endif
        tick(5);
        check("nack_err_once", err_cnt - e0, 1);
        check("nack_no_done", done_cnt - d0, 0);
        check("nack_idle", bus.busy, 1'b0);

        // Reset at falling edge 5 of SHIFT, then 0xF4 (five ones -> parity 0) completes.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h3C, 1'b0, 8'h00);
        device(1'b1, 5, 0, bits);
        tick(HALF);
        check("abort_no_done_err", {done_cnt - d0, err_cnt - e0}, 64'd0);
        send(8'hF4, 1'b0, 8'h00);
        device(1'b1, 0, 0, bits);
        tick(10);
        check("f4_byte", bits[7:0], 8'hF4);
        check("f4_parity", bits[8], 1'b0);
        check("f4_done", done_cnt - d0, 1);

        // 0xAA request pulsed during SHIFT of 0x55 is ignored.
        d0 = done_cnt;
        send(8'h55, 1'b0, 8'h00);
        device(1'b1, 0, 3, bits);
        tick(10);
        check("ignore_byte", bits[7:0], 8'h55);
        check("ignore_parity", bits[8], 1'b1);
        check("ignore_done_once", done_cnt - d0, 1);
        tick(INH * 3);
        check("ignore_no_second_send", bus.busy, 1'b0);

        check("done_err_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
